// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button edge detection, run/pause/clear FSM, tick divider
// and cascaded seconds/minutes/hours counters with a lap capture register.
module stopwatch_ctrl #(
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59,
    parameter int HOUR_MAX = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] num,
    input  logic        btn_ss,
    input  logic        btn_clr,
    input  logic        btn_lap,
    output logic [1:0]  state,
    output logic        tick,
    output logic [5:0]  sec,
    output logic [5:0]  min,
    output logic [4:0]  hour,
    output logic [5:0]  lap_sec,
    output logic [5:0]  lap_min,
    output logic [4:0]  lap_hour,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        BAD   = 2'b11
    } state_t;

    localparam logic [5:0] SEC_LAST  = 6'(SEC_MAX);
    localparam logic [5:0] MIN_LAST  = 6'(MIN_MAX);
    localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX);

    state_t      state_q;
    state_t      state_d;
    logic        ss_prev;
    logic        clr_prev;
    logic        lap_prev;
    logic        ss_evt;
    logic        clr_evt;
    logic        lap_evt;
    logic        clear_all;
    logic        div_hit;
    logic        sec_last;
    logic        min_last;
    logic        hour_last;
    logic [31:0] cnt_div;

    assign ss_evt  = btn_ss  & ~ss_prev;
    assign clr_evt = btn_clr & ~clr_prev;
    assign lap_evt = btn_lap & ~lap_prev;

    assign state     = state_q;
    assign clear_all = (state_q == PAUSE) && clr_evt;

    // num of 0 or 1 means every RUN cycle ticks; >= lets a shrinking num tick at once
    assign div_hit = (num <= 32'd1) || (cnt_div >= (num - 32'd1));
    assign tick    = (state_q == RUN) && div_hit;

    assign sec_last  = (sec  == SEC_LAST);
    assign min_last  = (min  == MIN_LAST);
    assign hour_last = (hour == HOUR_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ss_prev  <= 1'b0;
            clr_prev <= 1'b0;
            lap_prev <= 1'b0;
        end else begin
            state_q  <= state_d;
            ss_prev  <= btn_ss;
            clr_prev <= btn_clr;
            lap_prev <= btn_lap;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_evt) state_d = RUN;
            RUN:     if (ss_evt) state_d = PAUSE;
            PAUSE: begin
                if (clr_evt)     state_d = IDLE;
                else if (ss_evt) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_div <= 32'd0;
        end else if (clear_all || (state_q != RUN && state_q != PAUSE)) begin
            cnt_div <= 32'd0;
        end else if (state_q == RUN) begin
            cnt_div <= tick ? 32'd0 : cnt_div + 32'd1;
        end
    end

    // Cascade: each stage rolls over only when every lower stage is at its last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec  <= 6'd0;
            min  <= 6'd0;
            hour <= 5'd0;
            ovf  <= 1'b0;
        end else if (clear_all) begin
            sec  <= 6'd0;
            min  <= 6'd0;
            hour <= 5'd0;
            ovf  <= 1'b0;
        end else begin
            ovf <= tick && sec_last && min_last && hour_last;
            if (tick) begin
                if (!sec_last) begin
                    sec <= sec + 6'd1;
                end else begin
                    sec <= 6'd0;
                    if (!min_last) begin
                        min <= min + 6'd1;
                    end else begin
                        min  <= 6'd0;
                        hour <= hour_last ? 5'd0 : hour + 5'd1;
                    end
                end
            end
        end
    end

    // Captures the pre-edge time, so a same-edge increment is not included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_sec  <= 6'd0;
            lap_min  <= 6'd0;
            lap_hour <= 5'd0;
        end else if (clear_all) begin
            lap_sec  <= 6'd0;
            lap_min  <= 6'd0;
            lap_hour <= 5'd0;
        end else if ((state_q == RUN) && lap_evt) begin
            lap_sec  <= sec;
            lap_min  <= min;
            lap_hour <= hour;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl; hours wrap after 2 to keep the overflow run short.
module tb_stopwatch_ctrl;

    localparam int HOUR_LAST = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] num = 32'd4;
    logic        btn_ss = 1'b0;
    logic        btn_clr = 1'b0;
    logic        btn_lap = 1'b0;
    logic [1:0]  state;
    logic        tick;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic [5:0]  lap_sec;
    logic [5:0]  lap_min;
    logic [4:0]  lap_hour;
    logic        ovf;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .SEC_MAX (59),
        .MIN_MAX (59),
        .HOUR_MAX(HOUR_LAST)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .num     (num),
        .btn_ss  (btn_ss),
        .btn_clr (btn_clr),
        .btn_lap (btn_lap),
        .state   (state),
        .tick    (tick),
        .sec     (sec),
        .min     (min),
        .hour    (hour),
        .lap_sec (lap_sec),
        .lap_min (lap_min),
        .lap_hour(lap_hour),
        .ovf     (ovf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ss, input logic clr, input logic lap, input int cycles);
        btn_ss  = ss;
        btn_clr = clr;
        btn_lap = lap;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic applyReset(input logic [31:0] n);
        rst_n = 1'b0;
        num   = n;
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic startRun();
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_sec", 32'(sec), 32'd0);
        checkOutput("reset_ovf", 32'(ovf), 32'd0);
        checkOutput("reset_lap", 32'(lap_sec), 32'd0);

        // Divide by 4: tick on every 4th RUN cycle
        applyReset(32'd4);
        startRun();
        checkOutput("start_state", 32'(state), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            checkOutput("tick_div4", 32'(tick), 32'((k % 4) == 0));
            @(negedge clk);
        end
        checkOutput("div4_sec", 32'(sec), 32'd3);
        checkOutput("div4_min", 32'(min), 32'd0);
        checkOutput("div4_hour", 32'(hour), 32'd0);

        // Full cascade and overflow at 2:59:59
        applyReset(32'd1);
        startRun();
        applyStimulus(1'b0, 1'b0, 1'b0, 60);
        checkOutput("min_roll_sec", 32'(sec), 32'd0);
        checkOutput("min_roll_min", 32'(min), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 3540);
        checkOutput("hour_roll_hour", 32'(hour), 32'd1);
        checkOutput("hour_roll_min", 32'(min), 32'd0);
        checkOutput("hour_roll_sec", 32'(sec), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 7199);
        checkOutput("allmax_sec", 32'(sec), 32'd59);
        checkOutput("allmax_min", 32'(min), 32'd59);
        checkOutput("allmax_hour", 32'(hour), 32'(HOUR_LAST));
        checkOutput("allmax_ovf", 32'(ovf), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("wrap_sec", 32'(sec), 32'd0);
        checkOutput("wrap_min", 32'(min), 32'd0);
        checkOutput("wrap_hour", 32'(hour), 32'd0);
        checkOutput("wrap_ovf", 32'(ovf), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("ovf_pulse_end", 32'(ovf), 32'd0);
        checkOutput("after_wrap_sec", 32'(sec), 32'd1);

        // Pause holds the divider count, resume continues from it
        applyReset(32'd4);
        startRun();
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        checkOutput("pre_pause_sec", 32'(sec), 32'd2);
        startRun();
        checkOutput("pause_state", 32'(state), 32'd2);
        for (int k = 0; k < 20; k++) begin
            checkOutput("pause_tick", 32'(tick), 32'd0);
            @(negedge clk);
        end
        checkOutput("pause_sec", 32'(sec), 32'd2);
        startRun();
        checkOutput("resume_state", 32'(state), 32'd1);
        checkOutput("resume_tick", 32'(tick), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 6);
        checkOutput("resume_sec", 32'(sec), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        num = 32'd2;
        #1;
        checkOutput("num_drop_tick", 32'(tick), 32'd1);
        @(negedge clk);
        checkOutput("num_drop_sec", 32'(sec), 32'd5);

        // Lap capture while running, ignored while paused
        applyReset(32'd1);
        startRun();
        applyStimulus(1'b0, 1'b0, 1'b0, 5);
        checkOutput("lap_pre_sec", 32'(sec), 32'd5);
        applyStimulus(1'b0, 1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("lap_sec", 32'(lap_sec), 32'd5);
        checkOutput("lap_min", 32'(lap_min), 32'd0);
        checkOutput("lap_hour", 32'(lap_hour), 32'd0);
        checkOutput("lap_run_sec", 32'(sec), 32'd15);
        startRun();
        checkOutput("lap_pause_state", 32'(state), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("lap_pause_hold", 32'(lap_sec), 32'd5);
        checkOutput("lap_pause_sec", 32'(sec), 32'd16);

        // Clear ignored in RUN; simultaneous start/stop and clear in PAUSE clears
        startRun();
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("clr_run_state", 32'(state), 32'd1);
        checkOutput("clr_run_sec", 32'(sec), 32'd17);
        startRun();
        checkOutput("clr_pause_state", 32'(state), 32'd2);
        checkOutput("clr_pause_sec", 32'(sec), 32'd18);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("clr_state", 32'(state), 32'd0);
        checkOutput("clr_sec", 32'(sec), 32'd0);
        checkOutput("clr_lap_sec", 32'(lap_sec), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        checkOutput("clr_idle_hold", 32'(state), 32'd0);

        // Asynchronous reset between clock edges
        applyReset(32'd1);
        startRun();
        applyStimulus(1'b0, 1'b0, 1'b0, 7);
        checkOutput("prereset_sec", 32'(sec), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_state", 32'(state), 32'd0);
        checkOutput("async_sec", 32'(sec), 32'd0);
        checkOutput("async_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 5);
        checkOutput("post_reset_idle", 32'(state), 32'd0);
        checkOutput("post_reset_sec", 32'(sec), 32'd0);
        num = 32'd0;
        startRun();
        checkOutput("num0_state", 32'(state), 32'd1);
        checkOutput("num0_tick", 32'(tick), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        checkOutput("num0_sec", 32'(sec), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
